// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Decodes a 32-bit instruction into the control bundle and registers it as
//   the ID/EX control register (1 cycle latency). Adds a valid/ready handshake,
//   flush, and load-use hazard bubbling with a parameterised bubble count.
//
// Ports
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   instr_i, in_valid_i   instruction from IF/ID and its valid
//   in_ready_o            instruction accepted this cycle when in_valid_i=1
//   flush_i               discard the held bundle (taken branch/jump)
//   out_ready_i           EX accepts the bundle
//   out_valid_o           bundle valid
//   RegWrite_o .. Auipc_o registered controls; ImmSrc_o, ALUOp_o, J_o
//   rd_o, rs1_o, rs2_o, funct3_o, funct7b5_o   registered instruction fields
//   illegal_o             only with DECODE_ILLEGAL_TRAP_EN defined
//   hazard_stall_o        in_ready_o held low by load-use hazard logic
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds illegal_o).
//
// FSM states
//   state  | meaning
//   RUN    | normal operation, instructions may be accepted
//   BUBBLE | extra load-use bubbles still pending, in_ready_o held low

module decode_ctrl_pipe #(
    parameter int ILEN             = 32,
    parameter int IMMSRC_W         = 3,
    parameter int ALUOP_W          = 2,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [ILEN-1:0]     instr_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    input  logic                out_ready_i,
    output logic                out_valid_o,
    output logic                RegWrite_o,
    output logic                MemWrite_o,
    output logic                ALUSrc_o,
    output logic                ResultSrc_o,
    output logic                Branch_o,
    output logic                Auipc_o,
    output logic [IMMSRC_W-1:0] ImmSrc_o,
    output logic [ALUOP_W-1:0]  ALUOp_o,
    output logic [1:0]          J_o,
    output logic [4:0]          rd_o,
    output logic [4:0]          rs1_o,
    output logic [4:0]          rs2_o,
    output logic [2:0]          funct3_o,
    output logic                funct7b5_o,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                illegal_o,
`endif
    output logic                hazard_stall_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Counter preset after the first bubble; only meaningful when bubbling is enabled.
    localparam logic [1:0] CNT_INIT = 2'((LOAD_USE_BUBBLES > 0) ? LOAD_USE_BUBBLES - 1 : 0);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic [6:0] opc;
    logic       op_f7_ok;
    logic       unused_instr;

    logic                dec_reg_write, dec_mem_write, dec_alu_src, dec_result_src;
    logic                dec_branch, dec_auipc, uses_rs1, uses_rs2;
    logic [IMMSRC_W-1:0] dec_imm_src;
    logic [ALUOP_W-1:0]  dec_alu_op;
    logic [1:0]          dec_j;

    logic                out_valid_q, reg_write_q, mem_write_q, alu_src_q, result_src_q;
    logic                branch_q, auipc_q, funct7b5_q;
    logic [IMMSRC_W-1:0] imm_src_q;
    logic [ALUOP_W-1:0]  alu_op_q;
    logic [1:0]          j_q;
    logic [4:0]          rd_q, rs1_q, rs2_q;
    logic [2:0]          funct3_q;

    logic hazard, accept, xfer;

    assign opc          = instr_i[6:0];
    assign unused_instr = ^instr_i;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic dec_illegal, illegal_q;
    assign op_f7_ok    = (instr_i[31:25] == 7'b0000000) || (instr_i[31:25] == 7'b0100000);
    assign dec_illegal = !(opc inside {OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
                                       OPC_OP, OPC_BRANCH, OPC_JAL, OPC_JALR})
                         || ((opc == OPC_OP) && !op_f7_ok);
    assign illegal_o   = illegal_q;
`else
    assign op_f7_ok    = 1'b1;
`endif

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_result_src = 1'b0;
        dec_branch     = 1'b0;
        dec_auipc      = 1'b0;
        dec_imm_src    = '0;
        dec_alu_op     = '0;
        dec_j          = 2'b00;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        case (opc)
            OPC_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 1'b1;
                uses_rs1       = 1'b1;
            end
            OPC_STORE: begin
                dec_imm_src   = IMMSRC_W'(1);
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OPC_OPIMM: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALUOP_W'(2);
                uses_rs1      = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_imm_src   = IMMSRC_W'(4);
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALUOP_W'(3);
                dec_auipc     = (opc == OPC_AUIPC);
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                // An illegal funct7 leaves the bundle as a NOP.
                if (op_f7_ok) begin
                    dec_reg_write = 1'b1;
                    dec_alu_op    = ALUOP_W'(2);
                end
            end
            OPC_BRANCH: begin
                dec_imm_src = IMMSRC_W'(2);
                dec_branch  = 1'b1;
                dec_alu_op  = ALUOP_W'(1);
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
            end
            OPC_JAL: begin
                dec_reg_write = 1'b1;
                dec_imm_src   = IMMSRC_W'(3);
                dec_j         = 2'b01;
            end
            OPC_JALR: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = ALUOP_W'(2);
                dec_j         = 2'b10;
                uses_rs1      = 1'b1;
            end
            default: ;
        endcase
    end

    // A held load only stalls a consumer when it is actually leaving this cycle.
    assign hazard = (LOAD_USE_BUBBLES != 0) && in_valid_i && out_valid_q && result_src_q
                    && (rd_q != 5'd0) && out_ready_i
                    && ((uses_rs1 && (instr_i[19:15] == rd_q))
                        || (uses_rs2 && (instr_i[24:20] == rd_q)));

    assign xfer           = !out_valid_q || out_ready_i;
    assign in_ready_o     = rst_n_i && !flush_i && (state_q == ST_RUN) && !hazard && xfer;
    assign accept         = in_valid_i && in_ready_o;
    assign hazard_stall_o = rst_n_i && !flush_i
                            && ((state_q == ST_BUBBLE) || ((state_q == ST_RUN) && hazard));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        cnt_d   = CNT_INIT;
                        state_d = (CNT_INIT != 2'd0) ? ST_BUBBLE : ST_RUN;
                    end
                end
                ST_BUBBLE: begin
                    if (cnt_q <= 2'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_RUN;
            cnt_q        <= 2'd0;
            out_valid_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            alu_src_q    <= 1'b0;
            result_src_q <= 1'b0;
            branch_q     <= 1'b0;
            auipc_q      <= 1'b0;
            imm_src_q    <= '0;
            alu_op_q     <= '0;
            j_q          <= 2'b00;
            rd_q         <= 5'd0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            funct3_q     <= 3'd0;
            funct7b5_q   <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_i) begin
                out_valid_q <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal_q   <= 1'b0;
`endif
            end else if (accept) begin
                out_valid_q  <= 1'b1;
                reg_write_q  <= dec_reg_write;
                mem_write_q  <= dec_mem_write;
                alu_src_q    <= dec_alu_src;
                result_src_q <= dec_result_src;
                branch_q     <= dec_branch;
                auipc_q      <= dec_auipc;
                imm_src_q    <= dec_imm_src;
                alu_op_q     <= dec_alu_op;
                j_q          <= dec_j;
                rd_q         <= instr_i[11:7];
                rs1_q        <= instr_i[19:15];
                rs2_q        <= instr_i[24:20];
                funct3_q     <= instr_i[14:12];
                funct7b5_q   <= instr_i[30];
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal_q    <= dec_illegal;
`endif
            end else if (xfer) begin
                out_valid_q <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal_q   <= 1'b0;
`endif
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign RegWrite_o  = reg_write_q;
    assign MemWrite_o  = mem_write_q;
    assign ALUSrc_o    = alu_src_q;
    assign ResultSrc_o = result_src_q;
    assign Branch_o    = branch_q;
    assign Auipc_o     = auipc_q;
    assign ImmSrc_o    = imm_src_q;
    assign ALUOp_o     = alu_op_q;
    assign J_o         = j_q;
    assign rd_o        = rd_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign funct3_o    = funct3_q;
    assign funct7b5_o  = funct7b5_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: dut1 (1 load-use bubble) is scoreboarded, dut2
// (2 bubbles) shares the same stimulus and is used for bubble-count/flush tests.

module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] instr;

    logic       in_ready, out_valid, reg_write, mem_write, alu_src, result_src, branch, auipc;
    logic [2:0] imm_src, funct3;
    logic [1:0] alu_op, j;
    logic [4:0] rd, rs1, rs2;
    logic       funct7b5, hazard_stall, illegal;

    logic       in_ready2, out_valid2, reg_write2, mem_write2, alu_src2, result_src2, branch2, auipc2;
    logic [2:0] imm_src2, funct3_2;
    logic [1:0] alu_op2, j2;
    logic [4:0] rd2, rs1_2, rs2_2;
    logic       funct7b5_2, hazard_stall2, illegal2;

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.LOAD_USE_BUBBLES(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .flush_i(flush), .out_ready_i(out_ready),
        .out_valid_o(out_valid), .RegWrite_o(reg_write), .MemWrite_o(mem_write),
        .ALUSrc_o(alu_src), .ResultSrc_o(result_src), .Branch_o(branch),
        .Auipc_o(auipc), .ImmSrc_o(imm_src), .ALUOp_o(alu_op), .J_o(j),
        .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .funct3_o(funct3), .funct7b5_o(funct7b5),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal_o(illegal),
`endif
        .hazard_stall_o(hazard_stall)
    );

    decode_ctrl_pipe #(.LOAD_USE_BUBBLES(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .instr_i(instr), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .flush_i(flush), .out_ready_i(out_ready),
        .out_valid_o(out_valid2), .RegWrite_o(reg_write2), .MemWrite_o(mem_write2),
        .ALUSrc_o(alu_src2), .ResultSrc_o(result_src2), .Branch_o(branch2),
        .Auipc_o(auipc2), .ImmSrc_o(imm_src2), .ALUOp_o(alu_op2), .J_o(j2),
        .rd_o(rd2), .rs1_o(rs1_2), .rs2_o(rs2_2), .funct3_o(funct3_2), .funct7b5_o(funct7b5_2),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal_o(illegal2),
`endif
        .hazard_stall_o(hazard_stall2)
    );

`ifndef DECODE_ILLEGAL_TRAP_EN
    assign illegal  = 1'b0;
    assign illegal2 = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int sel    = 0;
    logic [32:0] sbq[$];
    logic [32:0] pack1, sb_exp;

    logic [6:0] opcs[10] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110111, 7'b0010111,
                             7'b0110011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};

    assign pack1 = {illegal, reg_write, imm_src, alu_src, mem_write, result_src, branch,
                    alu_op, j, auipc, rd, rs1, rs2, funct3, funct7b5};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdf, input logic [6:0] opc);
        return {f7, r2, r1, f3, rdf, opc};
    endfunction

    // Reference decode, written from the control table.
    function automatic logic [32:0] model(input logic [31:0] ins);
        logic [12:0] c;
        logic        ill;
        ill = 1'b0;
        case (ins[6:0])
            7'b0000011: c = 13'b1_000_1_0_1_0_00_00_0;
            7'b0100011: c = 13'b0_001_1_1_0_0_00_00_0;
            7'b0010011: c = 13'b1_000_1_0_0_0_10_00_0;
            7'b0110111: c = 13'b1_100_1_0_0_0_11_00_0;
            7'b0010111: c = 13'b1_100_1_0_0_0_11_00_1;
            7'b0110011: begin
                c = 13'b1_000_0_0_0_0_10_00_0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                if (ins[31:25] != 7'b0000000 && ins[31:25] != 7'b0100000) begin
                    c   = '0;
                    ill = 1'b1;
                end
`endif
            end
            7'b1100011: c = 13'b0_010_0_0_0_1_01_00_0;
            7'b1101111: c = 13'b1_011_0_0_0_0_00_01_0;
            7'b1100111: c = 13'b1_000_1_0_0_0_10_10_0;
            default: begin
                c = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
                ill = 1'b1;
`endif
            end
        endcase
        return {ill, c, ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[30]};
    endfunction

    function automatic logic cur_ready();
        return (sel == 1) ? in_ready2 : in_ready;
    endfunction
    function automatic logic cur_valid();
        return (sel == 1) ? out_valid2 : out_valid;
    endfunction
    function automatic logic cur_stall();
        return (sel == 1) ? hazard_stall2 : hazard_stall;
    endfunction

    // Scoreboard on dut1: push on accept, pop on transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 64'(out_valid), 64'(1'b0));
                end else begin
                    sb_exp = sbq.pop_front();
                    chk("sb_bundle", 64'(pack1), 64'(sb_exp));
                end
            end
            if (in_valid && in_ready) sbq.push_back(model(instr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic rnd);
        logic acc;
        int   guard;
        acc   = 1'b0;
        guard = 0;
        instr    = ins;
        in_valid = 1'b1;
        while (!acc && guard < 50) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = cur_ready();
            step();
            guard++;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic measure(input logic [31:0] ins, output int stalls, output int bubbles);
        logic acc;
        int   guard;
        acc     = 1'b0;
        guard   = 0;
        stalls  = 0;
        bubbles = 0;
        instr    = ins;
        in_valid = 1'b1;
        while (!acc && guard < 20) begin
            @(negedge clk);
            if (cur_stall()) stalls++;
            if (!cur_valid()) bubbles++;
            acc = cur_ready();
            step();
            guard++;
        end
        chk("measure_accept", 64'(acc), 64'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk(tag, 64'(sbq.size()), 64'(0));
    endtask

    task automatic load_use(input logic [4:0] ld_rd, input logic [31:0] dep,
                            input int exp_st, input int exp_bu, input string tag);
        int st, bu;
        send(enc(7'd0, 5'd0, 5'd1, 3'b010, ld_rd, 7'b0000011), 1'b0);
        measure(dep, st, bu);
        chk({tag, "_stalls"}, 64'(st), 64'(exp_st));
        chk({tag, "_bubbles"}, 64'(bu), 64'(exp_bu));
        drain({tag, "_drain"});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic [6:0] f7r;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        instr     = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011);

        // Reset with in_valid held high
        repeat (2) step();
        chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
        chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
        chk("rst_bundle", 64'(pack1), 64'(0));
        chk("rst_out_valid2", 64'(out_valid2), 64'(1'b0));
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'(1'b1));
        step();
        chk("rel_first_accept", 64'(out_valid), 64'(1'b1));
        in_valid = 1'b0;
        drain("rel_drain");

        // Decode sweep over every listed opcode plus an unknown one
        for (int i = 0; i < 10; i++) begin
            logic [2:0] f3;
            f3 = 3'(i);
            send(enc(i[0] ? 7'b0100000 : 7'b0000000, 5'd2, 5'd1, f3, 5'd3, opcs[i]), 1'b0);
        end
        send(enc(7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011), 1'b0);
        send(enc(7'b1111111, 5'd9, 5'd8, 3'd7, 5'd4, 7'b1111111), 1'b0);
        drain("sweep_drain");

        // Backpressure
        send(enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011), 1'b0);
        out_ready = 1'b0;
        instr     = enc(7'd0, 5'd0, 5'd4, 3'd0, 5'd9, 7'b0010011);
        in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
            chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
            chk("bp_hold", 64'(pack1), 64'(model(enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011))));
        end
        step();
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(1'b1));
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'(1'b1));
        chk("bp_next_bundle", 64'(pack1), 64'(model(enc(7'd0, 5'd0, 5'd4, 3'd0, 5'd9, 7'b0010011))));
        drain("bp_drain");

        // Flush discards a held bundle
        send(enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd7, 7'b0110011), 1'b0);
        out_ready = 1'b0;
        step();
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(1'b0));
        step();
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(1'b0));
        if (sbq.size() != 0) void'(sbq.pop_front());
        drain("flush_drain");

        // Load-use on dut1 (one bubble)
        sel = 0;
        load_use(5'd5, enc(7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011), 1, 1, "lu_rs1");
        load_use(5'd5, enc(7'd0, 5'd5, 5'd1, 3'd2, 5'd0, 7'b0100011), 1, 1, "lu_rs2_store");
        load_use(5'd0, enc(7'd0, 5'd1, 5'd0, 3'd0, 5'd6, 7'b0110011), 0, 0, "lu_x0");
        load_use(5'd5, enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011), 0, 0, "lu_indep");
        load_use(5'd5, enc(7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110111), 0, 0, "lu_lui");

        // dut2: two bubbles, then flush during BUBBLE
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sbq.delete();
        sel = 1;
        load_use(5'd5, enc(7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011), 2, 2, "lu2");
        send(enc(7'd0, 5'd0, 5'd1, 3'b010, 5'd5, 7'b0000011), 1'b0);
        instr    = enc(7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011);
        in_valid = 1'b1;
        step();
        chk("fl2_bubble_stall", 64'(hazard_stall2), 64'(1'b1));
        flush = 1'b1;
        #1;
        chk("fl2_in_ready", 64'(in_ready2), 64'(1'b0));
        chk("fl2_out_valid", 64'(out_valid2), 64'(1'b0));
        step();
        flush = 1'b0;
        #1;
        chk("fl2_run_ready", 64'(in_ready2), 64'(1'b1));
        chk("fl2_no_stall", 64'(hazard_stall2), 64'(1'b0));
        step();
        in_valid = 1'b0;
        chk("fl2_accept_valid", 64'(out_valid2), 64'(1'b1));
        chk("fl2_accept_rd", 64'(rd2), 64'(5'd6));
        sel = 0;
        drain("fl2_drain");

        // Random traffic with random backpressure
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: f7r = 7'b0000000;
                1: f7r = 7'b0100000;
                default: f7r = 7'b0000001;
            endcase
            send(enc(f7r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     3'($urandom), 5'($urandom_range(0, 7)), opcs[$urandom_range(0, 9)]), 1'b1);
        end
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Parametrised successor to the combinational main decoder.
- Decodes a full 32-bit instruction into the control bundle and registers it as the ID/EX control register, so latency is 1 cycle.
- Adds a valid/ready handshake, stall, flush, and load-use hazard bubbling with a configurable bubble count.
- Adds AUIPC decode. Every output is defined, with no X values.

Parameters:
- ILEN, 32, instruction width; bits [6:0], [11:7], [14:12], [19:15], [24:20], [30] are used.
- IMMSRC_W, 3, ImmSrc width.
- ALUOP_W, 2, ALUOp width.
- LOAD_USE_BUBBLES, 1, bubbles inserted on a load-use hazard; legal range 0..3; 0 disables detection.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr  in  ILEN  instruction from IF/ID
- in_valid  in  1  instr valid
- in_ready  out  1  decoder accepts instr this cycle
- flush  in  1  discard held instruction (branch/jump taken)
- out_ready  in  1  EX accepts the bundle
- out_valid  out  1  bundle valid
- RegWrite, MemWrite, ALUSrc, ResultSrc, Branch, Auipc  out  1 each  registered controls
- ImmSrc  out  IMMSRC_W  registered
- ALUOp  out  ALUOP_W  registered
- J  out  2  registered; 01 JAL, 10 JALR
- rd, rs1, rs2  out  5 each  registered fields
- funct3  out  3  registered
- funct7b5  out  1  registered instr[30]
- hazard_stall  out  1  high on every cycle in_ready is held low by hazard logic

Behaviour:
- Reset: while rst_n=0 at a clk edge, all registered outputs are cleared to 0, out_valid=0, state is RUN, and the bubble counter is 0. in_ready=0 while rst_n=0.
- Decode table (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, J, Auipc):
  - Load 0000011: 1, 000, 1, 0, 1, 0, 00, 00, 0
  - Store 0100011: 0, 001, 1, 1, 0, 0, 00, 00, 0
  - OP-IMM 0010011: 1, 000, 1, 0, 0, 0, 10, 00, 0
  - LUI 0110111: 1, 100, 1, 0, 0, 0, 11, 00, 0
  - AUIPC 0010111: 1, 100, 1, 0, 0, 0, 11, 00, 1
  - OP 0110011: 1, 000, 0, 0, 0, 0, 10, 00, 0
  - Branch 1100011: 0, 010, 0, 0, 0, 1, 01, 00, 0
  - JAL 1101111: 1, 011, 0, 0, 0, 0, 00, 01, 0
  - JALR 1100111: 1, 000, 1, 0, 0, 0, 10, 10, 0
  - Any other opcode: all zero (a safe NOP).
- Handshake:
  - Register transfer occurs when out_valid=0 or out_ready=1.
  - in_ready = rst_n & state==RUN & !hazard & (!out_valid | out_ready).
  - Accept when in_valid & in_ready: load decoded bundle, out_valid<=1.
  - Transfer without accept: out_valid<=0.
  - out_valid=1 & out_ready=0: all outputs hold stable.
- Hazard: the held bundle is valid, is a Load, rd!=0, and out_ready=1, and the incoming instruction uses a matching source:
  - rs1 is used by OP, OP-IMM, Load, Store, Branch, JALR.
  - rs2 is used by OP, Store, Branch.
- FSM RUN/BUBBLE:
  - In RUN, a hazard with LOAD_USE_BUBBLES>=1 deasserts in_ready; the load transfers out, out_valid<=0, and the counter is set to LOAD_USE_BUBBLES-1.
  - If the counter is 0, state stays RUN and the dependent instruction is accepted next cycle. Otherwise go to BUBBLE.
  - BUBBLE: in_ready=0, out_valid stays 0, the counter decrements, and state returns to RUN when it reaches 0.
  - Total bubbles equal LOAD_USE_BUBBLES.
- Flush has priority over everything except reset: out_valid<=0, state<=RUN, counter<=0, and no accept occurs that cycle (in_ready=0 while flush=1).
- Held load followed by a non-dependent instruction, or rd=x0: no bubble.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output illegal (1-bit, registered).
  - illegal=1 for an unlisted opcode, or OP with funct7 not in {0000000, 0100000}; the bundle stays all-zero.
  - illegal is cleared on reset and flush, and follows the out_valid hold rules.
- When undefined: the port is absent and unlisted opcodes decode silently as NOP.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all controls 0. Release -> first instr accepted next edge.
- Decode sweep: feed every listed opcode with out_ready=1 -> one cycle later the bundle matches the table exactly, including AUIPC Auipc=1, ImmSrc=100. An unknown opcode yields all zeros.
- Backpressure: accept ADD, then hold out_ready=0 for 3 cycles -> out_valid=1, bundle stable, in_ready=0. Release -> the next instr is accepted in the same cycle.
- Load-use with LOAD_USE_BUBBLES=1: `lw x5` then `add x6,x5,x1` -> exactly one cycle with out_valid=0 and hazard_stall=1, then ADD is issued. Repeat with `lw x0` and with `add x6,x1,x2` -> no bubble.
- Load-use with LOAD_USE_BUBBLES=2 and flush=1 during BUBBLE -> out_valid=0, state RUN, and the next in_valid instr is accepted on the following cycle.
- With DECODE_ILLEGAL_TRAP_EN: opcode 1111111 -> illegal=1 and RegWrite=0. OP with funct7=0000001 -> illegal=1.
